stop_watch_ctrl: RTL and testbench

//  Sequencing controller for the 3-digit BCD stopwatch counter (go/clr datapath).

---
 rtl/stop_watch_ctrl_pkg.sv | 22 ++
 rtl/stop_watch_ctrl_btn_edge.sv | 19 +
 rtl/stop_watch_ctrl.sv | 101 ++++++++++
 tb/tb_stop_watch_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/stop_watch_ctrl_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package stop_watch_ctrl_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [ST_W-1:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_LAP   = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  // Three BCD digits, most significant first.
  typedef struct packed {
    logic [BCD_W-1:0] d2;
    logic [BCD_W-1:0] d1;
    logic [BCD_W-1:0] d0;
  } bcd3_t;

endpackage

// File: rtl/stop_watch_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level; one press per rising edge.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic q;

  // q resets high so a button held through reset never yields a press.
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b1;
    else       q <= btn;
  end

  assign press = btn & ~q;

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch sequencing controller: button presses to go/clr, lap snapshot and display mux.
module stop_watch_ctrl
  import stop_watch_ctrl_pkg::*;
#(
  parameter int unsigned LAP_HOLD = 150_000_000,
  parameter int unsigned LHW      = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_ss,
  input  logic             btn_lr,
  input  logic [BCD_W-1:0] d2_in,
  input  logic [BCD_W-1:0] d1_in,
  input  logic [BCD_W-1:0] d0_in,
  output logic             go,
  output logic             clr,
  output logic [BCD_W-1:0] d2,
  output logic [BCD_W-1:0] d1,
  output logic [BCD_W-1:0] d0,
  output logic             running,
  output logic             lap_active
);

  state_t           state, state_nxt;
  logic             ss_press, lr_raw, lr_press;
  logic             hold_exp;
  logic [LHW-1:0]   hold_cnt;
  bcd3_t            lap_reg, live;

  btn_edge u_edge_ss (.clk(clk), .reset(reset), .btn(btn_ss), .press(ss_press));
  btn_edge u_edge_lr (.clk(clk), .reset(reset), .btn(btn_lr), .press(lr_raw));

  // Start/stop wins a simultaneous press.
  assign lr_press = lr_raw & ~ss_press;
  assign live     = '{d2: d2_in, d1: d1_in, d0: d0_in};
  assign hold_exp = (LAP_HOLD != 0) && (hold_cnt == LHW'(LAP_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nxt;
  end

  // Next state plus Moore output decode.
  always_comb begin
    state_nxt  = ST_CLEAR;
    go         = 1'b0;
    clr        = 1'b0;
    running    = 1'b0;
    lap_active = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr       = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        state_nxt = ss_press ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        go      = 1'b1;
        running = 1'b1;
        if (ss_press)      state_nxt = ST_PAUSE;
        else if (lr_press) state_nxt = ST_LAP;
        else               state_nxt = ST_RUN;
      end
      ST_LAP: begin
        go         = 1'b1;
        running    = 1'b1;
        lap_active = 1'b1;
        if (ss_press)      state_nxt = ST_PAUSE;
        else if (lr_press) state_nxt = ST_RUN;
        else if (hold_exp) state_nxt = ST_RUN;
        else               state_nxt = ST_LAP;
      end
      ST_PAUSE: begin
        if (ss_press)      state_nxt = ST_RUN;
        else if (lr_press) state_nxt = ST_CLEAR;
        else               state_nxt = ST_PAUSE;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Snapshot live digits on the edge that enters LAP.
  always_ff @(posedge clk) begin
    if (reset)                                       lap_reg <= '0;
    else if (state == ST_RUN && state_nxt == ST_LAP) lap_reg <= live;
  end

  // Counts only while staying in LAP, so every entry starts from zero.
  always_ff @(posedge clk) begin
    if (reset)
      hold_cnt <= '0;
    else if (LAP_HOLD != 0 && state == ST_LAP && state_nxt == ST_LAP)
      hold_cnt <= hold_cnt + LHW'(1);
    else
      hold_cnt <= '0;
  end

  assign {d2, d1, d0} = lap_active ? lap_reg : live;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with LAP_HOLD=20: vector table plus hand sequences.
module tb_stop_watch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_ss, btn_lr;
  logic [3:0] d2_in, d1_in, d0_in;
  logic       go, clr, running, lap_active;
  logic [3:0] d2, d1, d0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ss;
    logic        lr;
    logic [11:0] din;
    logic        go;
    logic        clr;
    logic        run;
    logic        lap;
    logic [11:0] dexp;
  } vec_t;

  vec_t vecs [23];

  stop_watch_ctrl #(.LAP_HOLD(20), .LHW(5)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .d2_in(d2_in), .d1_in(d1_in), .d0_in(d0_in),
    .go(go), .clr(clr), .d2(d2), .d1(d1), .d0(d0),
    .running(running), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic ss, input logic lr, input logic [11:0] din,
                              input logic g, input logic c, input logic r, input logic l,
                              input logic [11:0] dexp);
    vec_t v;
    v.ss = ss; v.lr = lr; v.din = din;
    v.go = g; v.clr = c; v.run = r; v.lap = l; v.dexp = dexp;
    return v;
  endfunction

  task automatic check(input logic g, input logic c, input logic r, input logic l,
                       input logic [11:0] dexp, input string tag);
    logic [15:0] got, exp;
    got = {go, clr, running, lap_active, d2, d1, d0};
    exp = {g, c, r, l, dexp};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: go/clr/run/lap/d got %b%b%b%b %h, expected %b%b%b%b %h",
               tag, go, clr, running, lap_active, {d2, d1, d0}, g, c, r, l, dexp);
    end
  endtask

  // Drive inputs at a falling edge, let one rising edge sample them, check at the next falling edge.
  task automatic apply(input logic ss, input logic lr, input logic [11:0] din,
                       input logic g, input logic c, input logic r, input logic l,
                       input logic [11:0] dexp, input string tag);
    btn_ss = ss;
    btn_lr = lr;
    {d2_in, d1_in, d0_in} = din;
    @(negedge clk);
    check(g, c, r, l, dexp, tag);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 12'h000, 0, 0, 0, 0, 12'h000);
    vecs[1]  = mk(0, 1, 12'h000, 0, 0, 0, 0, 12'h000);
    vecs[2]  = mk(0, 0, 12'h000, 0, 0, 0, 0, 12'h000);
    vecs[3]  = mk(1, 0, 12'h000, 1, 0, 1, 0, 12'h000);
    for (int i = 4; i <= 12; i++) vecs[i] = mk(1, 0, 12'h000, 1, 0, 1, 0, 12'h000);
    vecs[13] = mk(0, 0, 12'h000, 1, 0, 1, 0, 12'h000);
    vecs[14] = mk(1, 0, 12'h000, 0, 0, 0, 0, 12'h000);
    vecs[15] = mk(0, 0, 12'h000, 0, 0, 0, 0, 12'h000);
    vecs[16] = mk(1, 0, 12'h000, 1, 0, 1, 0, 12'h000);
    vecs[17] = mk(0, 0, 12'h123, 1, 0, 1, 0, 12'h123);
    vecs[18] = mk(0, 1, 12'h123, 1, 0, 1, 1, 12'h123);
    vecs[19] = mk(0, 0, 12'h124, 1, 0, 1, 1, 12'h123);
    vecs[20] = mk(0, 0, 12'h125, 1, 0, 1, 1, 12'h123);
    vecs[21] = mk(0, 1, 12'h126, 1, 0, 1, 0, 12'h126);
    vecs[22] = mk(0, 0, 12'h127, 1, 0, 1, 0, 12'h127);

    reset  = 1'b1;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    {d2_in, d1_in, d0_in} = 12'h456;
    repeat (2) @(negedge clk);
    check(0, 1, 0, 0, 12'h456, "in_reset");
    reset = 1'b0;
    #1;
    check(0, 1, 0, 0, 12'h456, "clear_after_reset");
    @(negedge clk);
    check(0, 0, 0, 0, 12'h456, "idle_after_clear");

    for (int i = 0; i < 23; i++)
      apply(vecs[i].ss, vecs[i].lr, vecs[i].din, vecs[i].go, vecs[i].clr,
            vecs[i].run, vecs[i].lap, vecs[i].dexp, $sformatf("vec%0d", i));

    // Auto-return: 20 LAP cycles from entry, then RUN with live digits.
    apply(0, 1, 12'h200, 1, 0, 1, 1, 12'h200, "lap_entry");
    for (int k = 0; k < 19; k++)
      apply(0, 0, 12'h210, 1, 0, 1, 1, 12'h200, $sformatf("lap_hold%0d", k));
    apply(0, 0, 12'h211, 1, 0, 1, 0, 12'h211, "lap_auto_return");
    apply(0, 0, 12'h212, 1, 0, 1, 0, 12'h212, "run_after_return");

    // A start/stop press on the expiry cycle goes to PAUSE, not RUN.
    apply(0, 1, 12'h300, 1, 0, 1, 1, 12'h300, "lap2_entry");
    for (int k = 0; k < 19; k++)
      apply(0, 0, 12'h310, 1, 0, 1, 1, 12'h300, $sformatf("lap2_hold%0d", k));
    apply(1, 0, 12'h311, 0, 0, 0, 0, 12'h311, "press_on_expiry");
    apply(0, 0, 12'h311, 0, 0, 0, 0, 12'h311, "pause_hold");

    // PAUSE + lap/reset gives one clr pulse, then IDLE.
    apply(0, 1, 12'h311, 0, 1, 0, 0, 12'h311, "clear_pulse");
    apply(0, 0, 12'h000, 0, 0, 0, 0, 12'h000, "idle_after_pulse");
    apply(0, 0, 12'h000, 0, 0, 0, 0, 12'h000, "idle_stays");

    // Simultaneous presses from RUN: start/stop only.
    apply(1, 0, 12'h000, 1, 0, 1, 0, 12'h000, "run_again");
    apply(0, 0, 12'h001, 1, 0, 1, 0, 12'h001, "run_live");
    apply(1, 1, 12'h002, 0, 0, 0, 0, 12'h002, "both_pressed");
    apply(1, 1, 12'h002, 0, 0, 0, 0, 12'h002, "both_held");
    apply(0, 0, 12'h002, 0, 0, 0, 0, 12'h002, "pause_not_clear");

    // Start/stop held through a mid-operation reset.
    reset  = 1'b1;
    btn_ss = 1'b1;
    btn_lr = 1'b0;
    repeat (2) @(negedge clk);
    check(0, 1, 0, 0, 12'h002, "reset_with_ss_held");
    reset = 1'b0;
    apply(1, 0, 12'h002, 0, 0, 0, 0, 12'h002, "held_idle0");
    apply(1, 0, 12'h002, 0, 0, 0, 0, 12'h002, "held_idle1");
    apply(1, 0, 12'h002, 0, 0, 0, 0, 12'h002, "held_idle2");
    apply(0, 0, 12'h002, 0, 0, 0, 0, 12'h002, "released_idle");
    apply(1, 0, 12'h002, 1, 0, 1, 0, 12'h002, "fresh_press_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
